// File: rtl/paged_memory_bank.sv
// rtl/paged_memory_bank.sv - paged word memory with request port, scan chain, LED tap; optional MEMBANK_PARITY_EN
module paged_memory_bank #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 32,
  parameter int LED_ADDR   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  addr_err,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out,
  output logic                  scan_done,
  output logic                  parity_err,
  output logic [6:0]            led_out
);

  // Each stored word carries an even-parity bit above the data when enabled;
  // that bit is also the first bit of the word seen by the scan chain.
`ifdef MEMBANK_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif
  localparam int CHAIN_LEN = MEM_SIZE * WORD_W;
  localparam int CNT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [WORD_W-1:0]       mem_q [MEM_SIZE];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rsp_valid_q, addr_err_q, scan_done_q, parity_err_q;
  logic [DATA_WIDTH-1:0]   data_out_q;

  logic                    accept;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic [WORD_W-1:0]       rd_word;
  logic [WORD_W-1:0]       wr_word;
  logic                    scan_wrap;
  logic                    rd_parity_bad;

  assign accept   = req_valid && req_ready;
  assign in_range = ({1'b0, address} < MEM_LIMIT);
  assign idx      = address[IDX_W-1:0];
  assign rd_word  = mem_q[idx];

`ifdef MEMBANK_PARITY_EN
  assign wr_word       = {^data_in, data_in};
  assign rd_parity_bad = ^rd_word;
`else
  assign wr_word       = data_in;
  assign rd_parity_bad = 1'b0;
`endif

  assign scan_wrap = scan_enable && (cnt_q == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: scan mode follows scan_enable
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_enable)  state_d = SCAN;
      SCAN:    if (!scan_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: requests only accepted when idle and no scan is being requested
  always_comb begin
    req_ready = 1'b0;
    if (state_q == IDLE && !scan_enable) req_ready = 1'b1;
  end

  // Shift counter: wraps at the chain length, cleared whenever scan is off
  always_comb begin
    cnt_d = '0;
    if (scan_enable) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Storage: whole-array right shift during scan, otherwise in-range writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
    end else if (scan_enable) begin
      mem_q[0] <= {scan_in, mem_q[0][WORD_W-1:1]};
      for (int i = 1; i < MEM_SIZE; i++) mem_q[i] <= {mem_q[i-1][0], mem_q[i][WORD_W-1:1]};
    end else if (accept && req_write && in_range) begin
      mem_q[idx] <= wr_word;
    end
  end

  // Read response and status pulses, one cycle after acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      scan_done_q  <= 1'b0;
      parity_err_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      rsp_valid_q  <= accept && !req_write;
      addr_err_q   <= accept && !in_range;
      scan_done_q  <= scan_wrap;
      parity_err_q <= accept && !req_write && in_range && rd_parity_bad;
      if (accept && !req_write) data_out_q <= in_range ? rd_word[DATA_WIDTH-1:0] : '0;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign addr_err   = addr_err_q;
  assign scan_done  = scan_done_q;
  assign parity_err = parity_err_q;
  assign data_out   = data_out_q;
  assign scan_out   = mem_q[MEM_SIZE-1][0];

  generate
    if (DATA_WIDTH >= 7) begin : g_led_wide
      assign led_out = mem_q[LED_ADDR][6:0];
    end else begin : g_led_narrow
      assign led_out = {{(7 - DATA_WIDTH){1'b0}}, mem_q[LED_ADDR][DATA_WIDTH-1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_paged_memory_bank.sv
// tb/tb_paged_memory_bank.sv - self-checking bench for paged_memory_bank against a flat bit-chain model
module tb_paged_memory_bank;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int MS  = 32;
  localparam int LED = 15;
`ifdef MEMBANK_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif
  localparam int L = MS * WW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write, req_ready;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in, data_out;
  logic          rsp_valid, addr_err;
  logic          scan_enable, scan_in, scan_out, scan_done, parity_err;
  logic [6:0]    led_out;

  int tests = 0;
  int fails = 0;

  // Model: the whole memory as one scan chain; index 0 is word 0's top bit
  logic          chain_m [L];
  int            scan_cnt_m;
  logic [DW-1:0] last_data_m;
  logic [WW-1:0] tgt [MS];

  paged_memory_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .LED_ADDR(LED)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .address(address), .data_in(data_in), .rsp_valid(rsp_valid), .data_out(data_out),
    .addr_err(addr_err), .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .scan_done(scan_done), .parity_err(parity_err), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_word(input int w);
    logic [WW-1:0] r;
    for (int b = 0; b < WW; b++) r[b] = chain_m[w*WW + WW-1-b];
    return r;
  endfunction

  task automatic model_set(input int w, input logic [WW-1:0] v);
    for (int b = 0; b < WW; b++) chain_m[w*WW + WW-1-b] = v[b];
  endtask

  task automatic model_clear();
    for (int j = 0; j < L; j++) chain_m[j] = 1'b0;
    scan_cnt_m  = 0;
    last_data_m = '0;
  endtask

  function automatic logic [WW-1:0] stored_form(input logic [DW-1:0] d);
`ifdef MEMBANK_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic logic exp_perr(input logic [WW-1:0] word);
`ifdef MEMBANK_PARITY_EN
    return ^word;
`else
    return word[0] & 1'b0;
`endif
  endfunction

  task automatic do_write(input int a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; address = AW'(a); data_in = d;
    @(posedge clk);
    if (a < MS) model_set(a, stored_form(d));
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1'b0);
    check("wr_addr_err", addr_err, (a >= MS));
    check("wr_led", led_out, model_word(LED) & 7'h7F);
  endtask

  task automatic do_read(input int a);
    logic [WW-1:0] w;
    logic [DW-1:0] exp_d;
    logic          exp_p;
    req_valid = 1'b1; req_write = 1'b0; address = AW'(a);
    check("rd_req_ready", req_ready, 1'b1);
    @(posedge clk);
    w     = (a < MS) ? model_word(a) : '0;
    exp_d = w[DW-1:0];
    exp_p = (a < MS) ? exp_perr(w) : 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_data_out", data_out, exp_d);
    check("rd_addr_err", addr_err, (a >= MS));
    check("rd_parity_err", parity_err, exp_p);
    last_data_m = exp_d;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_data_hold", data_out, last_data_m);
    check("idle_addr_err", addr_err, 1'b0);
  endtask

  task automatic scan_step(input logic b);
    scan_enable = 1'b1; scan_in = b;
    #1;
    check("scan_req_ready", req_ready, 1'b0);
    @(posedge clk);
    for (int j = L-1; j > 0; j--) chain_m[j] = chain_m[j-1];
    chain_m[0] = b;
    scan_cnt_m++;
    @(negedge clk);
    check("scan_done", scan_done, (scan_cnt_m == L));
    if (scan_cnt_m == L) scan_cnt_m = 0;
    check("scan_out", scan_out, chain_m[L-1]);
    check("scan_led", led_out, model_word(LED) & 7'h7F);
  endtask

  task automatic scan_stop();
    scan_enable = 1'b0; scan_in = 1'b0;
    scan_cnt_m  = 0;
    @(posedge clk);
    @(negedge clk);
    check("stop_scan_done", scan_done, 1'b0);
    check("stop_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; address = '0; data_in = '0;
    scan_enable = 1'b0; scan_in = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_led", led_out, 7'h00);
    check("rst_scan_out", scan_out, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // Write then immediate read of the same address
    do_write(3, 8'hA5);
    do_read(3);
    check("a5_data", data_out, 8'hA5);
    idle_cycle();

    // LED tap follows word 15
    do_write(15, 8'h7F);
    check("led_7f", led_out, 7'h7F);

    // Random mix of reads, writes and idle cycles, including out-of-range addresses
    for (int n = 0; n < 80; n++) begin
      int op, a;
      op = int'($urandom_range(0, 2));
      a  = int'($urandom_range(0, 63));
      if (op == 0)      do_write(a, DW'($urandom));
      else if (op == 1) do_read(a);
      else              idle_cycle();
    end

    // Out-of-range read
    do_read(40);
    check("oor_data_zero", data_out, '0);
    idle_cycle();
    check("oor_err_one_cycle", addr_err, 1'b0);

    // Full chain of ones, then every word reads back all ones
    for (int k = 0; k < L; k++) scan_step(1'b1);
    scan_stop();
    for (int w = 0; w < MS; w++) begin
      do_read(w);
      check("ones_word", data_out, 8'hFF);
    end

    // Partial scan is retained and restarts the counter
    for (int k = 0; k < 37; k++) scan_step(1'($urandom));
    scan_stop();
    for (int w = 0; w < MS; w += 5) do_read(w);

    // Full load with one word's parity deliberately inverted
    for (int w = 0; w < MS; w++) begin
      tgt[w] = stored_form(DW'($urandom));
`ifdef MEMBANK_PARITY_EN
      if (w == 5) tgt[w][DW] = ~tgt[w][DW];
`endif
    end
    for (int j = L-1; j >= 0; j--) scan_step(tgt[j / WW][WW-1 - (j % WW)]);
    scan_stop();
    for (int w = 0; w < MS; w++) begin
      do_read(w);
      check("load_word", data_out, tgt[w][DW-1:0]);
    end
`ifdef MEMBANK_PARITY_EN
    do_read(5);
    check("corrupt_parity_err", parity_err, 1'b1);
`endif

    // Short scan dropped early, then reset lands in the middle of a read
    for (int k = 0; k < 10; k++) scan_step(1'($urandom));
    scan_stop();
    req_valid = 1'b1; req_write = 1'b0; address = AW'(3);
    @(posedge clk);
    #2 rst = 1'b0;
    req_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check("midrd_rsp_valid", rsp_valid, 1'b0);
    check("midrd_data_out", data_out, '0);
    check("midrd_addr_err", addr_err, 1'b0);
    check("midrd_scan_done", scan_done, 1'b0);
    check("midrd_parity_err", parity_err, 1'b0);
    check("midrd_led", led_out, 7'h00);
    check("midrd_scan_out", scan_out, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    do_read(3);
    check("post_rst_data", data_out, '0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/paged_memory_bank.md
PAGED_MEMORY_BANK -- requirements
Module: paged_memory_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the address bus width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-003 Parameter MEM_SIZE, default 32, SHALL set the word count, with MEM_SIZE <= 2**ADDR_WIDTH.
REQ-004 Parameter LED_ADDR, default 15, SHALL select the word tapped onto led_out.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Port req_valid, input, 1: access request present.
REQ-009 Port req_ready, output, 1: request can be accepted this cycle.
REQ-010 Port req_write, input, 1: 1 means write, 0 means read.
REQ-011 Port address, input, ADDR_WIDTH: word address.
REQ-012 Port data_in, input, DATA_WIDTH: write data.
REQ-013 Port rsp_valid, output, 1: one-cycle pulse marking data_out valid for a read.
REQ-014 Port data_out, output, DATA_WIDTH: registered read data.
REQ-015 Port addr_err, output, 1: one-cycle pulse on an accepted out-of-range access.
REQ-016 Port scan_enable, input, 1: shift the whole array one bit per cycle.
REQ-017 Port scan_in / scan_out, input / output, 1 each: chain head / chain tail.
REQ-018 Port scan_done, output, 1: one-cycle pulse when a full chain length has been shifted.
REQ-019 Port parity_err, output, 1: parity mismatch on a read response (REQ-038).
REQ-020 Port led_out, output, 7: word LED_ADDR, bits [6:0], zero-extended if DATA_WIDTH < 7.

Function
REQ-021 The controller SHALL be an FSM with two states, IDLE and SCAN.
- IDLE to SCAN when scan_enable=1.
- SCAN to IDLE when scan_enable=0.
REQ-022 req_ready SHALL be 1 in IDLE with scan_enable=0, and 0 otherwise.
REQ-023 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-024 An accepted write with address < MEM_SIZE SHALL update that word at the same edge.
REQ-025 An accepted read SHALL present data_out with rsp_valid=1 exactly one cycle later (latency 1).
- data_out holds its value until the next read response.
REQ-026 A read on the cycle after a write to the same address SHALL return the new data.
REQ-027 On an accepted access with address >= MEM_SIZE:
- a write is discarded;
- a read returns data_out=0 with rsp_valid=1;
- addr_err pulses one cycle after acceptance.
REQ-028 Scan chain order SHALL be as follows.
- scan_in enters word 0 at bit DATA_WIDTH-1.
- Each word shifts right.
- Word i bit 0 feeds word i+1 bit DATA_WIDTH-1.
- scan_out is word MEM_SIZE-1 bit 0, combinational from storage.
REQ-029 A shift SHALL occur on every edge with scan_enable=1; requests are not accepted during scan.
REQ-030 A bit counter SHALL count shifts modulo the chain length L.
- L = MEM_SIZE*DATA_WIDTH, or as extended by REQ-037.
- scan_done pulses on the edge where the count wraps from L-1 to 0.
REQ-031 When scan_enable falls before a wrap, the counter SHALL clear to 0, no scan_done SHALL be issued, and partially shifted contents SHALL be retained.
REQ-032 led_out SHALL track word LED_ADDR continuously, including during scan.

Reset
REQ-033 rst=0 SHALL immediately clear the following:
- all words and data_out to 0;
- rsp_valid, addr_err, scan_done, parity_err to 0;
- the counter to 0;
- the FSM to IDLE.
REQ-034 Reset asserted mid-read SHALL suppress that read's rsp_valid.
REQ-035 Reset asserted mid-scan SHALL abort the scan without a scan_done pulse.

Configuration
REQ-036 Macro MEMBANK_PARITY_EN SHALL compile in per-word even parity.
REQ-037 With MEMBANK_PARITY_EN defined:
- each word stores a parity bit, written on accepted writes;
- the parity bit sits above bit DATA_WIDTH-1 in the scan chain;
- L = MEM_SIZE*(DATA_WIDTH+1).
REQ-038 With MEMBANK_PARITY_EN defined, parity_err SHALL pulse with rsp_valid when the stored parity mismatches the stored data.
REQ-039 Without MEMBANK_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be tied to 0.

Verification
REQ-040 Reset, write 0xA5 to address 3, then read address 3 next cycle -> one cycle after read acceptance, rsp_valid=1 and data_out=0xA5.
REQ-041 Write 0x7F to address 15 -> led_out=0x7F from the next cycle.
REQ-042 Read address 40 with ADDR_WIDTH=6 and MEM_SIZE=32 -> data_out=0, rsp_valid=1, addr_err=1 for one cycle.
REQ-043 Scan 256 ones with defaults -> scan_done pulses on the 256th edge, every word reads 0xFF, and req_ready=0 throughout the scan.
REQ-044 With parity enabled, scan in a word with corrupted parity, then read it -> parity_err=1 together with rsp_valid.
REQ-045 Drop scan_enable after 10 shifts, then reset mid-read -> no scan_done pulse, no rsp_valid, all outputs 0.
